vfu_result_queue: RTL and testbench
===================================

# vfu_result_queue

Parametrised result writeback stage for the VFU. It selects one of `NSRC` functional-unit result vectors per accepted operation, applies a per-lane write mask, and buffers results in a `DEPTH`-entry FIFO. Results drain through a valid/ready handshake. It sits between the VFU arithmetic units (mult/add/sub/bypass and future sources) and the vector register writeback port, decoupling unit completion from writeback stalls.

## Interface
- `WIDTH`, 16, bits per lane
- `N`, 4, lanes per vector
- `NSRC`, 4, number of result sources (≥2)
- `DEPTH`, 4, FIFO entries (power of 2, ≥2)
- `SELW`, `$clog2(NSRC)`, select width (derived, not overridden)
- `CNTW`, `$clog2(DEPTH+1)`, occupancy width (derived)

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  reset, asynchronous, active-low (asserts immediately when low; deasserts synchronously to `clk` upstream)
- `flush`  input  1  synchronous clear of FIFO contents and error flag
- `in_valid`  input  1  source presents an operation
- `in_ready`  output  1  queue can accept
- `sel`  input  SELW  source index; source `s` occupies `src_data[s*N*WIDTH +: N*WIDTH]`
- `lane_mask`  input  N  bit i=1 keeps lane i; 0 forces lane i to zero
- `src_data`  input  NSRC*N*WIDTH  all source result vectors, concatenated
- `out_valid`  output  1  head entry present
- `out_ready`  input  1  consumer accepts head
- `out_data`  output  N*WIDTH  head entry data
- `out_mask`  output  N  head entry lane mask
- `count`  output  CNTW  current occupancy, 0..DEPTH
- `err_sel`  output  1  sticky: an operation was accepted with `sel >= NSRC`

## Operation
- **Push** = `in_valid && in_ready`. **Pop** = `out_valid && out_ready`.
- `in_ready = (count < DEPTH)`, driven from registered state only, with no path from `out_ready`. A full queue therefore refuses a push even while popping.
- Enqueued data: lane i = `src_data` lane i of source `sel` if `lane_mask[i]`, else 0. `lane_mask` is stored alongside as `out_mask`.
- `sel >= NSRC` (only possible when NSRC is not a power of 2): the entry is still enqueued, with all-zero data and the given mask, and `err_sel` is set.
- `err_sel` stays set until `flush` or reset.
- FIFO storage: write pointer and read pointer of width `$clog2(DEPTH)`, wrapping modulo DEPTH. Occupancy is tracked in `count`.
- Push only: write slot at wr_ptr, wr_ptr+1, count+1. Pop only: rd_ptr+1, count−1. Push and pop together: both pointers advance and count is unchanged.
- `out_valid = (count != 0)`. `out_data`/`out_mask` = entry at rd_ptr when `out_valid`, else all zeros.
- `flush`: on that edge, count=0, pointers=0, err_sel=0. Flush has priority over a simultaneous push and/or pop; those are discarded. Storage contents need not be cleared.
- Push is ignored when `in_ready=0`. Pop is ignored when `out_valid=0`. The block never overflows or underflows.

## Timing
- Reset (`rst`=0, asynchronous): count=0, pointers=0, err_sel=0. Consequently out_valid=0, out_data=0, out_mask=0, in_ready=1.
- Reset mid-operation discards all entries immediately, with no clock edge required.
- Latency: a push at edge k makes the entry visible at the head from edge k (cycle k+1) when the queue was empty. The entry can pop at edge k+1 at the earliest.
- Throughput: one push and one pop per cycle while 0 < count < DEPTH.
- `in_valid` and `src_data` need not be held after a push. Once `out_valid`=1, head data is stable until it is popped or flushed.
- `err_sel` rises on the edge of the offending push.

## Test plan
- **Reset/idle:** drive rst=0 mid-cycle with count=3 → outputs go to zero asynchronously, in_ready=1, count=0. After release, idle cycles keep count=0.
- **Select and mask:** WIDTH=16, N=4. Source s lane i = 0x1000·(s+1)+i. Push sel=2 with mask=4'b1011 → out_data lanes {0x3000,0x3001,0x0000,0x3003}, out_mask=4'b1011, out_valid at next cycle.
- **Fill/full:** with out_ready=0, push 5 ops (sel=0..3,0) → first 4 accepted, count=4, in_ready=0, 5th not stored. Then out_ready=1 → pops come out in order sel 0,1,2,3, count reaches 0, out_data=0.
- **Simultaneous push/pop with wrap:** hold count=2 and push+pop for 10 cycles → count stays 2, output order matches input order across pointer wrap, no lost or duplicated entries.
- **Illegal select:** NSRC=3, push sel=3 mask=4'hF → entry data all zero, err_sel=1 and held. A later legal push leaves err_sel=1. A flush clears it.
- **Flush priority:** count=3, assert flush with in_valid=1 and out_ready=1 in the same cycle → next cycle count=0, out_valid=0, in_ready=1, err_sel=0.

Source files
------------

// File: rtl/vfu_result_queue.sv
// VFU result writeback queue: picks one of NSRC result vectors per accepted op,
// zeroes masked-off lanes, and buffers {data, mask} in a DEPTH-entry FIFO.
module vfu_result_queue #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int NSRC  = 4,
  parameter int DEPTH = 4,
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SELW-1:0]           sel,
  input  logic [N-1:0]              lane_mask,
  input  logic [NSRC*N*WIDTH-1:0]   src_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*WIDTH-1:0]        out_data,
  output logic [N-1:0]              out_mask,
  output logic [CNTW-1:0]           count,
  output logic                      err_sel
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int VW   = N * WIDTH;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on registered occupancy, never on out_ready.
  logic [VW-1:0]   data_q [DEPTH];
  logic [N-1:0]    mask_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic [VW-1:0]   src_vec;
  logic [VW-1:0]   wr_data;
  logic            sel_bad;
  logic            push;
  logic            pop;

  // An out-of-range select matches no source, so its vector stays zero.
  always_comb begin
    src_vec = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (sel == SELW'(s)) src_vec = src_data[s*VW +: VW];
    end
    wr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (lane_mask[i]) wr_data[i*WIDTH +: WIDTH] = src_vec[i*WIDTH +: WIDTH];
    end
  end

  assign sel_bad   = ({1'b0, sel} >= (SELW+1)'(NSRC));
  assign in_ready  = (count_q < CNTW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      if (push && !pop)      count_d = count_q + CNTW'(1);
      else if (pop && !push) count_d = count_q - CNTW'(1);
      if (push && sel_bad) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_q[wr_ptr_q] <= wr_data;
      mask_q[wr_ptr_q] <= lane_mask;
    end
  end

  assign out_data = out_valid ? data_q[rd_ptr_q] : '0;
  assign out_mask = out_valid ? mask_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign err_sel  = err_q;

endmodule

// File: tb/tb_vfu_result_queue.sv
// Bench for vfu_result_queue: an NSRC=4 and an NSRC=3 instance share stimulus
// and are each checked against a queue-based model after every clock edge.
module tb_vfu_result_queue;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  mask;
  } entry_t;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [3:0]  mask;
    logic        ordy;
    logic [2:0]  cnt;
    logic        vld;
    logic [63:0] data;
    logic [3:0]  omask;
    logic        irdy;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [1:0]   sel;
  logic [3:0]   lane_mask;
  logic [255:0] src_data;

  logic         in_ready4, out_valid4, err4;
  logic [63:0]  out_data4;
  logic [3:0]   out_mask4;
  logic [2:0]   count4;
  logic         in_ready3, out_valid3, err3;
  logic [63:0]  out_data3;
  logic [3:0]   out_mask3;
  logic [2:0]   count3;

  entry_t q4[$];
  entry_t q3[$];
  logic   merr4, merr3;
  int     n_cmp = 0;
  int     n_bad = 0;
  vec_t   tbl[11];

  always #5 clk = ~clk;

  vfu_result_queue #(.WIDTH(16), .N(4), .NSRC(4), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .sel(sel), .lane_mask(lane_mask), .src_data(src_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_mask(out_mask4), .count(count4), .err_sel(err4)
  );

  vfu_result_queue #(.WIDTH(16), .N(4), .NSRC(3), .DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .sel(sel), .lane_mask(lane_mask), .src_data(src_data[191:0]),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_mask(out_mask3), .count(count3), .err_sel(err3)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic entry_t make_entry(int nsrc);
    entry_t e;
    e.mask = lane_mask;
    e.data = '0;
    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i] && int'(sel) < nsrc)
        e.data[i*16 +: 16] = src_data[(int'(sel)*4 + i)*16 +: 16];
    end
    return e;
  endfunction

  // Model of one clock edge, evaluated on pre-edge state and inputs.
  function automatic void model_edge();
    bit push4, pop4, push3, pop3;
    if (flush) begin
      q4.delete(); q3.delete();
      merr4 = 1'b0; merr3 = 1'b0;
    end else begin
      push4 = in_valid && (q4.size() < 4);
      pop4  = out_ready && (q4.size() > 0);
      push3 = in_valid && (q3.size() < 4);
      pop3  = out_ready && (q3.size() > 0);
      if (pop4) void'(q4.pop_front());
      if (push4) q4.push_back(make_entry(4));
      if (pop3) void'(q3.pop_front());
      if (push3) q3.push_back(make_entry(3));
      if (push3 && sel >= 2'd3) merr3 = 1'b1;
    end
  endfunction

  function automatic void check_all();
    entry_t h4, h3;
    h4 = '{64'h0, 4'h0};
    h3 = '{64'h0, 4'h0};
    if (q4.size() != 0) h4 = q4[0];
    if (q3.size() != 0) h3 = q3[0];
    chk("d4.count",     64'(count4),     64'(q4.size()));
    chk("d4.out_valid", 64'(out_valid4), 64'(q4.size() != 0));
    chk("d4.in_ready",  64'(in_ready4),  64'(q4.size() < 4));
    chk("d4.out_data",  out_data4,       h4.data);
    chk("d4.out_mask",  64'(out_mask4),  64'(h4.mask));
    chk("d4.err_sel",   64'(err4),       64'(merr4));
    chk("d3.count",     64'(count3),     64'(q3.size()));
    chk("d3.out_valid", 64'(out_valid3), 64'(q3.size() != 0));
    chk("d3.in_ready",  64'(in_ready3),  64'(q3.size() < 4));
    chk("d3.out_data",  out_data3,       h3.data);
    chk("d3.out_mask",  64'(out_mask3),  64'(h3.mask));
    chk("d3.err_sel",   64'(err3),       64'(merr3));
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(logic iv, logic [1:0] s, logic [3:0] m, logic ordy, logic fl);
    in_valid  = iv;
    sel       = s;
    lane_mask = m;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic set_pattern();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 4; i++)
        src_data[(s*4 + i)*16 +: 16] = 16'((s + 1) * 16'h1000 + i);
  endtask

  task automatic randomize_src();
    for (int k = 0; k < 8; k++) src_data[k*32 +: 32] = $urandom;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'd2, 4'b1011, 1'b0, 3'd1, 1'b1, 64'h3003_0000_3001_3000, 4'b1011, 1'b1};
    tbl[1]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 3'd0, 1'b0, 64'h0, 4'h0, 1'b1};
    tbl[2]  = '{1'b1, 2'd0, 4'hF, 1'b0, 3'd1, 1'b1, 64'h1003_1002_1001_1000, 4'hF, 1'b1};
    tbl[3]  = '{1'b1, 2'd1, 4'hF, 1'b0, 3'd2, 1'b1, 64'h1003_1002_1001_1000, 4'hF, 1'b1};
    tbl[4]  = '{1'b1, 2'd2, 4'hF, 1'b0, 3'd3, 1'b1, 64'h1003_1002_1001_1000, 4'hF, 1'b1};
    tbl[5]  = '{1'b1, 2'd3, 4'hF, 1'b0, 3'd4, 1'b1, 64'h1003_1002_1001_1000, 4'hF, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 4'hF, 1'b0, 3'd4, 1'b1, 64'h1003_1002_1001_1000, 4'hF, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 4'hF, 1'b1, 3'd3, 1'b1, 64'h2003_2002_2001_2000, 4'hF, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 4'hF, 1'b1, 3'd2, 1'b1, 64'h3003_3002_3001_3000, 4'hF, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 4'hF, 1'b1, 3'd1, 1'b1, 64'h4003_4002_4001_4000, 4'hF, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 4'hF, 1'b1, 3'd0, 1'b0, 64'h0, 4'h0, 1'b1};

    merr4 = 1'b0;
    merr3 = 1'b0;
    src_data = '0;
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    step();

    // Table: select/mask, fill to full, refused push while full, drain in order
    set_pattern();
    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].iv, tbl[k].sel, tbl[k].mask, tbl[k].ordy, 1'b0);
      step();
      chk($sformatf("tbl%0d.count", k),    64'(count4),     64'(tbl[k].cnt));
      chk($sformatf("tbl%0d.valid", k),    64'(out_valid4), 64'(tbl[k].vld));
      chk($sformatf("tbl%0d.data", k),     out_data4,       tbl[k].data);
      chk($sformatf("tbl%0d.mask", k),     64'(out_mask4),  64'(tbl[k].omask));
      chk($sformatf("tbl%0d.in_ready", k), 64'(in_ready4),  64'(tbl[k].irdy));
    end
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
    step();

    // Simultaneous push/pop across pointer wrap at count=2
    for (int k = 0; k < 2; k++) begin
      randomize_src();
      drive(1'b1, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      step();
    end
    for (int k = 0; k < 10; k++) begin
      randomize_src();
      drive(1'b1, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
      step();
      chk("wrap.count4", 64'(count4), 64'd2);
    end
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
    step();

    // Illegal select on the NSRC=3 instance, sticky error
    set_pattern();
    drive(1'b1, 2'd3, 4'hF, 1'b0, 1'b0);
    step();
    chk("illegal.data", out_data3, 64'h0);
    chk("illegal.mask", 64'(out_mask3), 64'hF);
    chk("illegal.err", 64'(err3), 64'd1);
    drive(1'b1, 2'd1, 4'hF, 1'b0, 1'b0);
    step();
    chk("legal_after.err", 64'(err3), 64'd1);
    drive(1'b1, 2'd0, 4'h5, 1'b0, 1'b0);
    step();
    chk("pre_flush.count", 64'(count3), 64'd3);

    // Flush wins over simultaneous push and pop
    drive(1'b1, 2'd2, 4'hF, 1'b1, 1'b1);
    step();
    chk("flush.count", 64'(count3), 64'd0);
    chk("flush.valid", 64'(out_valid3), 64'd0);
    chk("flush.in_ready", 64'(in_ready3), 64'd1);
    chk("flush.err", 64'(err3), 64'd0);

    // Asynchronous reset mid-cycle with count=3
    drive(1'b1, 2'd3, 4'hF, 1'b0, 1'b0);
    repeat (3) step();
    chk("pre_reset.count", 64'(count4), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    q4.delete(); q3.delete();
    merr4 = 1'b0; merr3 = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 1'b1, 1'b0);
    repeat (2) step();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      randomize_src();
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 39) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
